// File: rtl/ptr_sync_gray.sv
// Multi-stage Gray pointer synchroniser for the async FIFO: brings a foreign-domain
// Gray pointer into clk, decodes it, and qualifies it with valid/changed/error flags.
module ptr_sync_gray #(
  parameter int WIDTH       = 5,
  parameter int STAGES      = 2,
  parameter int GRAY_DECODE = 1
) (
  input  logic             clk,
  input  logic             rest,
  input  logic [WIDTH-1:0] ptr_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] ptr_sync_out,
  output logic [WIDTH-1:0] ptr_bin_out,
  output logic             ptr_valid,
  output logic             ptr_changed,
  output logic             gray_err
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("ptr_sync_gray: STAGES must be 2..4");
  end
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("ptr_sync_gray: WIDTH must be 2..16");
  end

  localparam int CW = $clog2(STAGES + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(STAGES + 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STAGES);

  logic [WIDTH-1:0] s [STAGES];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;
  logic             acc;
  logic [CW-1:0]    cnt;

  assign ptr_sync_out = s[STAGES-1];

  // s[0] is the metastability capture flop; nothing may sit between stages.
  always_ff @(posedge clk) begin
    if (rest) begin
      for (int n = 0; n < STAGES; n++) s[n] <= '0;
    end else begin
      s[0] <= ptr_in;
      for (int n = 1; n < STAGES; n++) s[n] <= s[n-1];
    end
  end

  always_comb begin
    dec = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ ptr_sync_out[i];
      dec[i] = acc;
    end
    bin_next = (GRAY_DECODE != 0) ? dec : ptr_sync_out;
  end

  // More than one bit set in diff <=> clearing the lowest set bit leaves something.
  assign diff      = ptr_sync_out ^ prev;
  assign multi_bit = (diff & (diff - WIDTH'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rest) begin
      prev        <= '0;
      ptr_bin_out <= '0;
      cnt         <= '0;
      ptr_valid   <= 1'b0;
      ptr_changed <= 1'b0;
      gray_err    <= 1'b0;
    end else begin
      prev        <= ptr_sync_out;
      ptr_bin_out <= bin_next;
      if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      if (cnt == CNT_PRE) ptr_valid <= 1'b1;
      ptr_changed <= ptr_valid && (diff != '0);
      if (ptr_valid && multi_bit) gray_err <= 1'b1;
      else if (err_clr)           gray_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ptr_sync_gray.sv
// Directed bench for ptr_sync_gray: three instances (2 stages decoded, 4 stages decoded,
// 2 stages raw) share one stimulus stream; expectations are hand-computed per instance.
module tb_ptr_sync_gray;

  logic       clk;
  logic       rest;
  logic [4:0] ptr_in;
  logic       err_clr;

  logic [4:0] u2_sync, u2_bin, u4_sync, u4_bin, u0_sync, u0_bin;
  logic       u2_valid, u2_chg, u2_err;
  logic       u4_valid, u4_chg, u4_err;
  logic       u0_valid, u0_chg, u0_err;

  int total = 0;
  int bad   = 0;

  ptr_sync_gray #(.WIDTH(5), .STAGES(2), .GRAY_DECODE(1)) u2 (
    .clk(clk), .rest(rest), .ptr_in(ptr_in), .err_clr(err_clr),
    .ptr_sync_out(u2_sync), .ptr_bin_out(u2_bin), .ptr_valid(u2_valid),
    .ptr_changed(u2_chg), .gray_err(u2_err));

  ptr_sync_gray #(.WIDTH(5), .STAGES(4), .GRAY_DECODE(1)) u4 (
    .clk(clk), .rest(rest), .ptr_in(ptr_in), .err_clr(err_clr),
    .ptr_sync_out(u4_sync), .ptr_bin_out(u4_bin), .ptr_valid(u4_valid),
    .ptr_changed(u4_chg), .gray_err(u4_err));

  ptr_sync_gray #(.WIDTH(5), .STAGES(2), .GRAY_DECODE(0)) u0 (
    .clk(clk), .rest(rest), .ptr_in(ptr_in), .err_clr(err_clr),
    .ptr_sync_out(u0_sync), .ptr_bin_out(u0_bin), .ptr_valid(u0_valid),
    .ptr_changed(u0_chg), .gray_err(u0_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  initial begin
    rest    = 1'b1;
    ptr_in  = 5'b00110;
    err_clr = 1'b0;

    // reset held for 3 edges: everything reads 0
    for (int i = 0; i < 3; i++) begin
      tick();
      chk5("rst_sync", u2_sync, 5'b0);
      chk5("rst_bin", u2_bin, 5'b0);
      chk1("rst_valid", u2_valid, 1'b0);
      chk1("rst_chg", u2_chg, 1'b0);
      chk1("rst_err", u2_err, 1'b0);
      chk5("rst_bin_u4", u4_bin, 5'b0);
    end
    rest = 1'b0;

    // flush after release
    tick();
    chk1("flush1_valid", u2_valid, 1'b0);
    chk1("flush1_chg", u2_chg, 1'b0);
    tick();
    chk1("flush2_valid", u2_valid, 1'b0);
    chk5("flush2_sync", u2_sync, 5'b00110);
    chk1("flush2_chg", u2_chg, 1'b0);
    tick();
    chk1("flush3_valid", u2_valid, 1'b1);
    chk5("flush3_bin", u2_bin, 5'b00100);
    chk5("flush3_bin_raw", u0_bin, 5'b00110);
    chk1("flush3_chg", u2_chg, 1'b0);
    chk1("flush3_valid_u4", u4_valid, 1'b0);
    tick();
    chk1("flush4_valid_u4", u4_valid, 1'b0);
    chk5("flush4_sync_u4", u4_sync, 5'b00110);
    chk1("flush4_chg", u2_chg, 1'b0);
    tick();
    chk1("flush5_valid_u4", u4_valid, 1'b1);
    chk5("flush5_bin_u4", u4_bin, 5'b00100);
    chk1("flush5_chg_u4", u4_chg, 1'b0);
    tick();
    chk1("flush6_chg_u4", u4_chg, 1'b0);

    // walk back to 0 in legal single-bit steps
    ptr_in = 5'b00010;
    tick();
    ptr_in = 5'b00000;
    repeat (6) tick();
    chk1("walk_err", u2_err, 1'b0);
    chk1("walk_err_u4", u4_err, 1'b0);
    chk5("walk_bin", u2_bin, 5'b00000);

    // latency 0 -> 1
    ptr_in = 5'b00001;
    tick();
    chk5("lat1_sync", u2_sync, 5'b00000);
    tick();
    chk5("lat2_sync", u2_sync, 5'b00001);
    chk5("lat2_bin", u2_bin, 5'b00000);
    chk1("lat2_chg", u2_chg, 1'b0);
    tick();
    chk5("lat3_bin", u2_bin, 5'b00001);
    chk1("lat3_chg", u2_chg, 1'b1);
    chk5("lat3_sync_u4", u4_sync, 5'b00000);
    tick();
    chk1("lat4_chg", u2_chg, 1'b0);
    chk5("lat4_sync_u4", u4_sync, 5'b00001);
    chk1("lat4_chg_u4", u4_chg, 1'b0);
    tick();
    chk5("lat5_bin_u4", u4_bin, 5'b00001);
    chk1("lat5_chg_u4", u4_chg, 1'b1);
    tick();
    chk1("lat6_chg_u4", u4_chg, 1'b0);

    // wrap: Gray count 1..31 then 0, one step per cycle
    ptr_in = 5'b00000;
    repeat (6) tick();
    for (int j = 1; j <= 35; j++) begin
      ptr_in = (j <= 32) ? gray(j) : 5'b00000;
      tick();
      if (j >= 3 && j <= 34) begin
        chk5("wrap_bin", u2_bin, 5'((j - 2) % 32));
        chk5("wrap_raw", u0_bin, gray(j - 2));
        chk1("wrap_chg", u2_chg, 1'b1);
      end
      chk1("wrap_err", u2_err, 1'b0);
    end
    repeat (4) tick();
    chk1("wrap_err_u4", u4_err, 1'b0);
    chk1("wrap_idle_chg", u2_chg, 1'b0);
    chk5("wrap_end_bin_u4", u4_bin, 5'b00000);

    // integrity error 00000 -> 00011
    ptr_in = 5'b00011;
    tick();
    tick();
    chk1("jump2_err", u2_err, 1'b0);
    tick();
    chk5("jump3_bin", u2_bin, 5'b00010);
    chk1("jump3_chg", u2_chg, 1'b1);
    chk1("jump3_err", u2_err, 1'b1);
    chk1("jump3_err_raw", u0_err, 1'b1);
    chk5("jump3_bin_raw", u0_bin, 5'b00011);
    tick();
    tick();
    chk1("jump5_err_u4", u4_err, 1'b1);
    chk1("jump5_err", u2_err, 1'b1);
    chk1("jump5_chg", u2_chg, 1'b0);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("clr_err", u2_err, 1'b0);
    chk1("clr_err_u4", u4_err, 1'b0);
    tick();
    chk1("clr_err_hold", u2_err, 1'b0);

    // set wins over simultaneous clear: 00011 -> 00000
    ptr_in = 5'b00000;
    tick();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("setclr_err", u2_err, 1'b1);
    chk1("setclr_err_raw", u0_err, 1'b1);
    chk5("setclr_bin", u2_bin, 5'b00000);
    chk1("setclr_chg", u2_chg, 1'b1);
    tick();
    chk1("setclr_sticky", u2_err, 1'b1);
    repeat (4) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("setclr_cleared", u2_err, 1'b0);
    chk1("setclr_cleared_u4", u4_err, 1'b0);

    // mid-operation reset while 01100 is in flight
    ptr_in = 5'b01100;
    tick();
    rest = 1'b1;
    tick();
    rest = 1'b0;
    chk5("mid_rst_sync", u0_sync, 5'b0);
    chk5("mid_rst_bin", u0_bin, 5'b0);
    chk1("mid_rst_valid", u0_valid, 1'b0);
    chk1("mid_rst_chg", u0_chg, 1'b0);
    chk1("mid_rst_err", u0_err, 1'b0);
    tick();
    chk1("mid1_chg", u0_chg, 1'b0);
    chk1("mid1_valid", u0_valid, 1'b0);
    tick();
    chk1("mid2_chg", u0_chg, 1'b0);
    chk5("mid2_sync", u0_sync, 5'b01100);
    chk1("mid2_valid", u0_valid, 1'b0);
    tick();
    chk1("mid3_chg", u0_chg, 1'b0);
    chk1("mid3_valid", u0_valid, 1'b1);
    chk5("mid3_bin_raw", u0_bin, 5'b01100);
    chk5("mid3_bin_dec", u2_bin, 5'b01000);
    chk1("mid3_err", u0_err, 1'b0);
    tick();
    chk1("mid4_chg", u0_chg, 1'b0);
    chk1("mid4_err", u0_err, 1'b0);
    tick();
    chk1("mid5_chg_u4", u4_chg, 1'b0);
    chk1("mid5_valid_u4", u4_valid, 1'b1);
    tick();
    chk1("mid6_chg_u4", u4_chg, 1'b0);
    chk1("mid6_err_u4", u4_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ptr_sync_gray.md
# ptr_sync_gray

Parametrised multi-stage pointer synchroniser for the async FIFO. It brings a Gray-coded FIFO pointer from the foreign clock domain into the local `clk` domain and decodes it to binary. It qualifies the result with a post-reset valid flag, a one-cycle change strobe, and a sticky Gray-integrity error. It sits on both the read side and the write side of the FIFO, feeding full/empty comparison logic. It supersedes the fixed two-flop, raw-pass-through pointer synchroniser.

## Interface
Parameters:
- `WIDTH`, default 5: pointer width in bits, including the wrap bit. Legal range 2..16.
- `STAGES`, default 2: number of synchroniser flops. Legal range 2..4. Other values are an elaboration error.
- `GRAY_DECODE`, default 1: 1 = `ptr_bin_out` is the Gray-to-binary decode; 0 = `ptr_bin_out` is a registered copy of the raw Gray value.

Ports:
- `clk` in 1: local-domain clock. One clock only; all state is updated on its rising edge.
- `rest` in 1: synchronous reset, active-high.
- `ptr_in` in WIDTH: Gray-coded pointer from the foreign domain. Asynchronous to `clk`. At most one bit changes per foreign update.
- `err_clr` in 1: clears `gray_err` (single-cycle pulse or level).
- `ptr_sync_out` out WIDTH: raw Gray value at the last synchroniser stage.
- `ptr_bin_out` out WIDTH: registered decoded pointer.
- `ptr_valid` out 1: high once the pipeline has been flushed after reset.
- `ptr_changed` out 1: one-cycle strobe, high in the same cycle that `ptr_bin_out` takes a new value.
- `gray_err` out 1: sticky flag. Set when the synchronised value moves by more than one bit between consecutive cycles.

## Operation
- Synchroniser chain: `s[0] <= ptr_in`, `s[n] <= s[n-1]` for n = 1..STAGES-1.
  - `ptr_sync_out = s[STAGES-1]`.
  - No logic between stages.
- History register: `prev <= ptr_sync_out` every cycle.
- Decode:
  - `bin[WIDTH-1] = g[WIDTH-1]`.
  - `bin[i] = bin[i+1] ^ g[i]`.
  - Registered as `ptr_bin_out <= decode(ptr_sync_out)`, or `<= ptr_sync_out` when GRAY_DECODE = 0.
- Valid counter:
  - Saturating, width clog2(STAGES+2).
  - Cleared by `rest`; increments each cycle until it reaches STAGES+1.
  - `ptr_valid` is registered high from the cycle the count reaches STAGES+1. It stays high until the next `rest`.
- Change strobe: `ptr_changed <= ptr_valid && (ptr_sync_out != prev)`.
- Gray check:
  - d = popcount(`ptr_sync_out ^ prev`).
  - If `ptr_valid && d > 1`, then `gray_err <= 1`.
  - Otherwise, if `err_clr`, then `gray_err <= 0`.
  - Set wins over a simultaneous `err_clr`.
- Wrap-around: the Gray code wraps from max to 0 with a single-bit change (5-bit: 10000 -> 00000). This is a legal step and must not flag an error. The decode wraps 31 -> 0.
- Reset clears all flops: `s[*]`, `prev`, `ptr_bin_out`, the counter, `ptr_changed`, `ptr_valid`, `gray_err`. All outputs read 0 in the cycle after the reset edge.
- Reset mid-operation: all state returns to 0 regardless of the value in flight. `ptr_valid` must re-qualify (STAGES+1 cycles), and no `ptr_changed` pulse may occur for the value flushed in.

## Timing
- `ptr_in` stable before edge E appears on `ptr_sync_out` after edge E+STAGES-1, i.e. STAGES edges.
- It appears on `ptr_bin_out` and raises `ptr_changed` one edge later: STAGES+1 edges total.
- `gray_err` asserts on the same edge as the offending `ptr_changed`.
- `ptr_valid` rises on the (STAGES+1)-th edge after the last edge with `rest` = 1.
- `ptr_changed` is a single cycle per distinct value. When the value changes every cycle, it stays high continuously.
- Throughput: one new value per cycle. There is no handshake and no back-pressure.
- Timing constraints: `s[0]` is a false-path/max-delay endpoint. Constraints are owned by the FIFO top.

## Test plan
- Reset/flush, STAGES=2:
  - Stimulus: hold `rest` 3 cycles with `ptr_in` = 00110, then release.
  - Required response: all outputs 0 while `rest` is high. `ptr_valid` rises on the 3rd edge after release. `ptr_bin_out` = 00100. No `ptr_changed` pulse.
- Latency:
  - Stimulus: after valid, step `ptr_in` 00000 -> 00001.
  - Required response: `ptr_sync_out` = 00001 after 2 edges. `ptr_bin_out` = 00001 and a one-cycle `ptr_changed` pulse after 3 edges. With STAGES=4: 4 and 5 edges respectively.
- Wrap:
  - Stimulus: count Gray 0..31 and back to 0, one step per cycle.
  - Required response: `ptr_bin_out` follows 0..31 then 0. `ptr_changed` is high every cycle. `gray_err` stays 0.
- Integrity error:
  - Stimulus: jump `ptr_in` 00000 -> 00011.
  - Required response: `gray_err` = 1 on the same edge that `ptr_bin_out` = 00010, and it stays 1 afterwards.
  - Stimulus: one `err_clr` pulse with no new error.
  - Required response: `gray_err` clears one edge later.
- Set-vs-clear:
  - Stimulus: assert `err_clr` on the edge where a two-bit jump is detected.
  - Required response: `gray_err` = 1.
- Mid-operation reset with GRAY_DECODE=0:
  - Stimulus: while `ptr_in` = 01100 is in flight, pulse `rest` for 1 cycle.
  - Required response: outputs read 0 the next cycle. `ptr_bin_out` = 01100 (raw) after re-flush. `ptr_changed` stays 0 throughout.
